// File: rtl/ysyx_25050147_exu_wbu_pkg.sv
// Shared widths, writeback entry layout and reset values for the EXU->WBU stage.
// Combinational definitions only; no latency, no flow control.
package ysyx_25050147_exu_wbu_pkg;
  localparam int DEF_XLEN   = 32;
  localparam int DEF_REG_AW = 5;

  typedef struct packed {
    logic [DEF_REG_AW-1:0] rd;
    logic [DEF_XLEN-1:0]   wdata;
    logic                  wen;
  } entry_t;

  localparam logic [DEF_XLEN-1:0] RESET_REDIRECT_PC  = '0;
  localparam logic                RESET_REDIRECT_VLD = 1'b0;
endpackage

// File: rtl/ysyx_25050147_exu_wbu_if.sv
// Handshake bundle: ALU-stage input, WBU-side output and fetch redirect.
// Wires only; no latency. Flow control is valid/ready on both the in and out sides.
interface ysyx_25050147_exu_wbu_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_alu_res;
  logic              in_is_br;
  logic              in_is_jal;
  logic              in_is_jalr;
  logic [REG_AW-1:0] in_rd;
  logic              in_rd_wen;
  logic              out_valid;
  logic              out_ready;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_wdata;
  logic              out_wen;
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;

  modport master (
    output in_valid, in_pc, in_imm, in_alu_res, in_is_br, in_is_jal, in_is_jalr, in_rd, in_rd_wen,
    output out_ready,
    input  in_ready, out_valid, out_rd, out_wdata, out_wen, redirect_valid, redirect_pc
  );

  modport slave (
    input  in_valid, in_pc, in_imm, in_alu_res, in_is_br, in_is_jal, in_is_jalr, in_rd, in_rd_wen,
    input  out_ready,
    output in_ready, out_valid, out_rd, out_wdata, out_wen, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/ysyx_25050147_skid_fifo2.sv
// Generic 2-entry valid/ready FIFO; push-to-pop latency 1 cycle, head driven from registers.
// o_push_rdy depends only on occupancy (not on i_pop_rdy); head data holds while not popped.
module ysyx_25050147_skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push_vld,
  output logic         o_push_rdy,
  input  logic [W-1:0] i_push_dat,
  output logic         o_pop_vld,
  input  logic         i_pop_rdy,
  output logic [W-1:0] o_pop_dat
);
  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  assign o_push_rdy = (r_count != 2'd2);
  assign o_pop_vld  = (r_count != 2'd0);
  assign o_pop_dat  = r_mem[r_rd_ptr];
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = o_pop_vld && i_pop_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end
endmodule

// File: rtl/ysyx_25050147_exu_wbu.sv
// Resolves branch/jump outcome, queues rd writeback in a 2-entry FIFO, registers a 1-cycle redirect.
// Accept-to-out_valid latency 1; in_ready drops when the FIFO is full or a redirect is being issued.
module ysyx_25050147_exu_wbu
  import ysyx_25050147_exu_wbu_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = DEF_REG_AW
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_25050147_exu_wbu_if.slave   bus
);
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wdata;
    logic              wen;
  } wb_entry_t;

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;
  logic [XLEN-1:0] w_snpc;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_npc;
  logic [XLEN-1:0] w_wdata;
  logic            w_fifo_rdy;
  logic            w_accept;
  wb_entry_t       w_push_entry;
  wb_entry_t       w_head;

  assign w_snpc   = bus.in_pc + XLEN'(4);
  assign w_target = bus.in_pc + bus.in_imm;

  always_comb begin
    w_npc   = w_snpc;
    w_wdata = bus.in_alu_res;
    if (bus.in_is_br) begin
      if (bus.in_alu_res[0]) w_npc = w_target;
    end else if (bus.in_is_jal) begin
      w_npc   = w_target;
      w_wdata = w_snpc;
    end else if (bus.in_is_jalr) begin
      w_npc   = bus.in_alu_res & ~XLEN'(1);
      w_wdata = w_snpc;
    end
  end

  // Branches never write rd, even if decode wrongly set rd_wen.
  assign w_push_entry.rd    = bus.in_rd;
  assign w_push_entry.wdata = w_wdata;
  assign w_push_entry.wen   = bus.in_rd_wen && !bus.in_is_br && (bus.in_rd != '0);

  assign bus.in_ready = w_fifo_rdy && !r_redirect_valid;
  assign w_accept     = bus.in_valid && bus.in_ready;

  ysyx_25050147_skid_fifo2 #(.W($bits(wb_entry_t))) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push_vld (w_accept),
    .o_push_rdy (w_fifo_rdy),
    .i_push_dat (w_push_entry),
    .o_pop_vld  (bus.out_valid),
    .i_pop_rdy  (bus.out_ready),
    .o_pop_dat  (w_head)
  );

  assign bus.out_rd    = w_head.rd;
  assign bus.out_wdata = w_head.wdata;
  assign bus.out_wen   = w_head.wen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_redirect_valid <= RESET_REDIRECT_VLD;
      r_redirect_pc    <= XLEN'(RESET_REDIRECT_PC);
    end else begin
      r_redirect_valid <= w_accept && (w_npc != w_snpc);
      if (w_accept && (w_npc != w_snpc)) r_redirect_pc <= w_npc;
    end
  end

  assign bus.redirect_valid = r_redirect_valid;
  assign bus.redirect_pc    = r_redirect_pc;
endmodule

// File: tb/tb_ysyx_25050147_exu_wbu.sv
// Directed bench for ysyx_25050147_exu_wbu: drives and samples 1 time unit after each rising edge.
module tb_ysyx_25050147_exu_wbu;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  ysyx_25050147_exu_wbu_if #(.XLEN(32), .REG_AW(5)) bus ();

  ysyx_25050147_exu_wbu #(.XLEN(32), .REG_AW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] res,
                       input logic br, input logic jal, input logic jalr,
                       input logic [4:0] rd, input logic wen);
    bus.in_valid   = 1'b1;
    bus.in_pc      = pc;
    bus.in_imm     = imm;
    bus.in_alu_res = res;
    bus.in_is_br   = br;
    bus.in_is_jal  = jal;
    bus.in_is_jalr = jalr;
    bus.in_rd      = rd;
    bus.in_rd_wen  = wen;
  endtask

  // Present one instruction, confirm it can be accepted, clock it in, then idle the input.
  task automatic issue(input string tag, input logic [31:0] pc, input logic [31:0] imm,
                       input logic [31:0] res, input logic br, input logic jal, input logic jalr,
                       input logic [4:0] rd, input logic wen);
    drive(pc, imm, res, br, jal, jalr, rd, wen);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst_out_wdata", bus.out_wdata, 32'd0);
    chk("rst_out_wen", 32'(bus.out_wen), 32'd0);
    chk("rst_redirect_valid", 32'(bus.redirect_valid), 32'd0);
    chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;
    tick();

    // Fill to two entries, then reset mid-stream.
    issue("fill0", 32'h100, 32'h0, 32'h11, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    issue("fill1", 32'h104, 32'h0, 32'h22, 1'b0, 1'b0, 1'b0, 5'd4, 1'b1);
    chk("full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("full_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("postrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("postrst_redirect", 32'(bus.redirect_valid), 32'd0);

    // ADD
    bus.out_ready = 1'b1;
    issue("add", 32'h80000000, 32'h0, 32'h15, 1'b0, 1'b0, 1'b0, 5'd5, 1'b1);
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_out_rd", 32'(bus.out_rd), 32'd5);
    chk("add_out_wdata", bus.out_wdata, 32'h15);
    chk("add_out_wen", 32'(bus.out_wen), 32'd1);
    chk("add_redirect", 32'(bus.redirect_valid), 32'd0);
    tick();
    chk("add_drained", 32'(bus.out_valid), 32'd0);

    // BEQ taken, with a wrong-path instruction presented during the redirect cycle.
    issue("beq_t", 32'h80000010, 32'hFFFFFFF8, 32'h1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("beq_t_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("beq_t_redirect_pc", bus.redirect_pc, 32'h80000008);
    chk("beq_t_in_ready", 32'(bus.in_ready), 32'd0);
    chk("beq_t_out_valid", 32'(bus.out_valid), 32'd1);
    chk("beq_t_out_wen", 32'(bus.out_wen), 32'd0);
    drive(32'h80000014, 32'h0, 32'h77, 1'b0, 1'b0, 1'b0, 5'd9, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    chk("wrongpath_dropped", 32'(bus.out_valid), 32'd0);
    chk("beq_t_pulse_end", 32'(bus.redirect_valid), 32'd0);

    // BEQ not taken; rd_wen=1 on a branch must still give wen=0.
    issue("beq_nt", 32'h80000010, 32'hFFFFFFF8, 32'h0, 1'b1, 1'b0, 1'b0, 5'd7, 1'b1);
    chk("beq_nt_redirect", 32'(bus.redirect_valid), 32'd0);
    chk("beq_nt_out_valid", 32'(bus.out_valid), 32'd1);
    chk("beq_nt_out_wen", 32'(bus.out_wen), 32'd0);
    tick();

    // JALR
    issue("jalr", 32'h80000020, 32'h0, 32'h80000103, 1'b0, 1'b0, 1'b1, 5'd1, 1'b1);
    chk("jalr_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("jalr_redirect_pc", bus.redirect_pc, 32'h80000102);
    chk("jalr_out_wdata", bus.out_wdata, 32'h80000024);
    chk("jalr_out_wen", 32'(bus.out_wen), 32'd1);
    tick();
    issue("jalr_x0", 32'h80000020, 32'h0, 32'h80000103, 1'b0, 1'b0, 1'b1, 5'd0, 1'b1);
    chk("jalr_x0_out_wen", 32'(bus.out_wen), 32'd0);
    chk("jalr_x0_redirect", 32'(bus.redirect_valid), 32'd1);
    tick();

    // Backpressure
    bus.out_ready = 1'b0;
    issue("bp0", 32'h80000100, 32'h0, 32'hA, 1'b0, 1'b0, 1'b0, 5'd10, 1'b1);
    issue("bp1", 32'h80000104, 32'h0, 32'hB, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
    chk("bp_full_in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_head_rd", 32'(bus.out_rd), 32'd10);
    tick();
    chk("bp_hold_wdata", bus.out_wdata, 32'hA);
    chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    drive(32'h80000108, 32'h0, 32'hC, 1'b0, 1'b0, 1'b0, 5'd12, 1'b1);
    #1;
    chk("bp_rdy_no_comb_path", 32'(bus.in_ready), 32'd0);
    tick();
    chk("bp_pop0_rd", 32'(bus.out_rd), 32'd11);
    chk("bp_pop0_wdata", bus.out_wdata, 32'hB);
    chk("bp_pop0_in_ready", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_pushpop_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_pushpop_rd", 32'(bus.out_rd), 32'd12);
    chk("bp_pushpop_wdata", bus.out_wdata, 32'hC);
    tick();
    chk("bp_drained", 32'(bus.out_valid), 32'd0);

    // JAL with PC wrap
    issue("jal_wrap", 32'hFFFFFFFC, 32'h8, 32'h0, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    chk("jal_wrap_wdata", bus.out_wdata, 32'h00000000);
    chk("jal_wrap_redirect", 32'(bus.redirect_valid), 32'd1);
    chk("jal_wrap_redirect_pc", bus.redirect_pc, 32'h00000004);
    tick();
    chk("jal_wrap_pulse_end", 32'(bus.redirect_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
